// File: rtl/bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// bus_bridge_pkg
// Definitions shared by both halves of the UART bus bridge: the bus-side
// target endpoint and the remote initiator wrapper.
//   BRIDGE_CMD_WRITE / BRIDGE_CMD_READ : first byte of a request frame
//   BRIDGE_RSP_ACK   / BRIDGE_RSP_DATA : first byte of a response frame
//   bridge_tgt_state_t                 : state encoding of the target FSM
// -----------------------------------------------------------------------------
package bus_bridge_pkg;

  localparam logic [7:0] BRIDGE_CMD_WRITE = 8'h57;  // 'W' + ADDR_HI + ADDR_LO + DATA
  localparam logic [7:0] BRIDGE_CMD_READ  = 8'h52;  // 'R' + ADDR_HI + ADDR_LO
  localparam logic [7:0] BRIDGE_RSP_ACK   = 8'h4B;  // 'K' : write completed remotely
  localparam logic [7:0] BRIDGE_RSP_DATA  = 8'h44;  // 'D' + DATA : read response

  typedef enum logic [3:0] {
    IDLE,
    WAIT_WDATA,
    SEND_CMD,
    SEND_AH,
    SEND_AL,
    SEND_D,
    WAIT_HDR,
    WAIT_RDATA,
    SPLIT_REQ,
    RETURN
  } bridge_tgt_state_t;

endpackage

// File: rtl/bridge_rsp_timer.sv
// -----------------------------------------------------------------------------
// bridge_rsp_timer
// Loadable down-counter that bounds how long the target waits for a response
// frame. It is loaded when the last request byte leaves, counts down while
// enabled, and flags expiry in the cycle the count sits at zero.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : load load_value (takes priority over counting)
//   load_value  : cycles-1 until expiry
//   enable      : count while waiting for a response
//   expired     : high while enabled with the count at zero
// -----------------------------------------------------------------------------
module bridge_rsp_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = enable && !load && (cnt == '0);

endmodule

// File: rtl/bus_bridge_target_uart.sv
// -----------------------------------------------------------------------------
// bus_bridge_target_uart
// Bus-side target of the UART bus bridge. Each local bus transaction is sent
// as a byte frame to the remote initiator. Writes complete in-line when the
// remote acknowledges; reads are split: the bus is released with
// target_split_ack and the data is handed back through split_req/split_grant
// once the response frame arrives.
//
// Optional feature: define BUS_BRIDGE_TARGET_TIMEOUT_EN to bound the response
// wait to TIMEOUT_CYCLES cycles (writes are then acked, reads return ERR_DATA)
// and to count timeouts in timeout_count. Without it the block waits forever
// and timeout_count reads 0.
//
// Ports:
//   clk, rst                                : clock, synchronous active-high reset
//   target_addr_in/_valid, target_rw        : address strobe, 1 = read
//   target_data_in/_valid                   : write data strobe
//   target_data_out/_valid                  : read data return
//   target_ack                              : transaction complete pulse
//   target_split_ack                        : read accepted as split
//   target_ready                            : idle, address can be accepted
//   split_req, split_grant                  : bus request for the split return
//   tx_data/tx_valid/tx_ready               : byte stream to the UART TX
//   rx_data/rx_valid                        : byte strobe from the UART RX
//   timeout_count                           : saturating timed-out count
// -----------------------------------------------------------------------------
module bus_bridge_target_uart
  import bus_bridge_pkg::*;
#(
  parameter int          INTERNAL_ADDR_BITS = 12,
  parameter logic [15:0] REMOTE_BASE        = 16'h0000,
  parameter int          TIMEOUT_CYCLES     = 100000,
  parameter logic [7:0]  ERR_DATA           = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] target_addr_in,
  input  logic        target_addr_in_valid,
  input  logic [7:0]  target_data_in,
  input  logic        target_data_in_valid,
  input  logic        target_rw,
  input  logic        split_grant,
  output logic [7:0]  target_data_out,
  output logic        target_data_out_valid,
  output logic        target_ack,
  output logic        target_split_ack,
  output logic        target_ready,
  output logic        split_req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  timeout_count
);

  localparam logic [15:0] ADDR_MASK = 16'((32'd1 << INTERNAL_ADDR_BITS) - 32'd1);

  bridge_tgt_state_t state;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic              is_read;

  logic [15:0]       fwd_addr;
  logic              rsp_match;
  logic              tmo_fire;

  // Local offset bits are kept, everything above is supplied by REMOTE_BASE.
  assign fwd_addr = REMOTE_BASE | (target_addr_in & ADDR_MASK);

  // A byte that advances the response wait: the expected header in WAIT_HDR,
  // or any byte in WAIT_RDATA (the payload of the read response).
  assign rsp_match = rx_valid &&
                     (((state == WAIT_HDR) &&
                       (rx_data == (is_read ? BRIDGE_RSP_DATA : BRIDGE_RSP_ACK))) ||
                      (state == WAIT_RDATA));

`ifdef BUS_BRIDGE_TARGET_TIMEOUT_EN
  logic rsp_expired;
  logic enter_wait;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The timer is reloaded on the edge that moves the FSM into WAIT_HDR.
  assign enter_wait = tx_ready &&
                      (((state == SEND_AL) && is_read) || (state == SEND_D));

  bridge_rsp_timer #(
    .CNT_W(32)
  ) u_rsp_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (enter_wait),
    .load_value(32'(TIMEOUT_CYCLES - 1)),
    .enable    ((state == WAIT_HDR) || (state == WAIT_RDATA)),
    .expired   (rsp_expired)
  );

  // A byte arriving in the expiry cycle still wins over the timeout.
  assign tmo_fire = rsp_expired && !rsp_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_count <= '0;
    end else if (tmo_fire) begin
      timeout_count <= sat_inc8(timeout_count);
    end
  end
`else
  logic [31:0] unused_tmo_cycles;

  assign unused_tmo_cycles = 32'(TIMEOUT_CYCLES);
  assign tmo_fire          = 1'b0;
  assign timeout_count     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      target_ready          <= 1'b1;
      target_ack            <= 1'b0;
      target_split_ack      <= 1'b0;
      target_data_out_valid <= 1'b0;
      target_data_out       <= '0;
      split_req             <= 1'b0;
      tx_valid              <= 1'b0;
      tx_data               <= '0;
    end else begin
      // Completion strobes are single-cycle pulses.
      target_ack            <= 1'b0;
      target_split_ack      <= 1'b0;
      target_data_out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (target_addr_in_valid) begin
            addr_q       <= fwd_addr;
            is_read      <= target_rw;
            target_ready <= 1'b0;
            if (target_rw) begin
              target_split_ack <= 1'b1;
              tx_valid         <= 1'b1;
              tx_data          <= BRIDGE_CMD_READ;
              state            <= SEND_CMD;
            end else if (target_data_in_valid) begin
              wdata_q  <= target_data_in;
              tx_valid <= 1'b1;
              tx_data  <= BRIDGE_CMD_WRITE;
              state    <= SEND_CMD;
            end else begin
              state <= WAIT_WDATA;
            end
          end
        end

        WAIT_WDATA: begin
          if (target_data_in_valid) begin
            wdata_q  <= target_data_in;
            tx_valid <= 1'b1;
            tx_data  <= BRIDGE_CMD_WRITE;
            state    <= SEND_CMD;
          end
        end

        // Each SEND_* state presents one byte and holds it until tx_ready.
        SEND_CMD: begin
          if (tx_ready) begin
            tx_data <= addr_q[15:8];
            state   <= SEND_AH;
          end
        end

        SEND_AH: begin
          if (tx_ready) begin
            tx_data <= addr_q[7:0];
            state   <= SEND_AL;
          end
        end

        SEND_AL: begin
          if (tx_ready) begin
            if (is_read) begin
              tx_valid <= 1'b0;
              state    <= WAIT_HDR;
            end else begin
              tx_data <= wdata_q;
              state   <= SEND_D;
            end
          end
        end

        SEND_D: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAIT_HDR;
          end
        end

        WAIT_HDR: begin
          if (rsp_match) begin
            if (is_read) begin
              state <= WAIT_RDATA;
            end else begin
              target_ack <= 1'b1;
              state      <= RETURN;
            end
          end else if (tmo_fire) begin
            if (is_read) begin
              rdata_q   <= ERR_DATA;
              split_req <= 1'b1;
              state     <= SPLIT_REQ;
            end else begin
              target_ack <= 1'b1;
              state      <= RETURN;
            end
          end
        end

        WAIT_RDATA: begin
          if (rsp_match) begin
            rdata_q   <= rx_data;
            split_req <= 1'b1;
            state     <= SPLIT_REQ;
          end else if (tmo_fire) begin
            rdata_q   <= ERR_DATA;
            split_req <= 1'b1;
            state     <= SPLIT_REQ;
          end
        end

        // Grant is checked from the first cycle split_req is visible.
        SPLIT_REQ: begin
          if (split_grant) begin
            split_req             <= 1'b0;
            target_ack            <= 1'b1;
            target_data_out_valid <= 1'b1;
            target_data_out       <= rdata_q;
            state                 <= RETURN;
          end
        end

        RETURN: begin
          target_ready <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          target_ready <= 1'b1;
          tx_valid     <= 1'b0;
          split_req    <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_bridge_target_uart.md
# bus_bridge_target_uart

Bus-side target endpoint of the UART bus bridge: sits on the local bus as a split-capable target and forwards each transaction as a byte frame to the remote bridge initiator, which replays it on the far bus. Writes complete in-line once the remote acknowledges. Reads are split: the bus is released, and data is returned via the split request/grant handshake when the response frame arrives. Byte transport is an existing UART TX/RX pair connected through a valid/ready byte stream.

## Interface
- `INTERNAL_ADDR_BITS`, default 12: local address bits forwarded; upper bits are replaced by `REMOTE_BASE`.
- `REMOTE_BASE`, default 16'h0000: OR-ed into the forwarded address.
- `TIMEOUT_CYCLES`, default 100000: response wait limit; only used with the timeout feature.
- `ERR_DATA`, default 8'hFF: read data returned on timeout.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `target_addr_in`  in  16  bus address
- `target_addr_in_valid`  in  1  address/rw strobe
- `target_data_in`  in  8  write data
- `target_data_in_valid`  in  1  write data strobe
- `target_rw`  in  1  1 = read, 0 = write; sampled with the address
- `split_grant`  in  1  bus grant for split return
- `target_data_out`  out  8  read data
- `target_data_out_valid`  out  1  read data strobe
- `target_ack`  out  1  transaction complete pulse
- `target_split_ack`  out  1  read accepted as split
- `target_ready`  out  1  idle, can accept an address
- `split_req`  out  1  request bus for split return
- `tx_data`  out  8  byte to UART TX
- `tx_valid`  out  1  byte valid
- `tx_ready`  in  1  UART TX can take a byte
- `rx_data`  in  8  byte from UART RX
- `rx_valid`  in  1  single-cycle received byte strobe
- `timeout_count`  out  8  saturating count of timed-out transactions

## Operation
- Forwarded address = `REMOTE_BASE | zero-extended target_addr_in[INTERNAL_ADDR_BITS-1:0]`.
- Request frames are sent most-significant byte first.
  - Write: 8'h57, ADDR_HI, ADDR_LO, DATA.
  - Read: 8'h52, ADDR_HI, ADDR_LO.
- Response frames:
  - Write acknowledge: 8'h4B.
  - Read response: 8'h44, DATA.
- FSM states: IDLE, WAIT_WDATA, SEND_CMD, SEND_AH, SEND_AL, SEND_D, WAIT_HDR, WAIT_RDATA, SPLIT_REQ, RETURN.
- IDLE: on `target_addr_in_valid` capture the forwarded address and `target_rw`.
  - Read: go to SEND_CMD.
  - Write: if `target_data_in_valid` is high in the same cycle, capture data and go to SEND_CMD; otherwise go to WAIT_WDATA.
- WAIT_WDATA: capture data on `target_data_in_valid`, then go to SEND_CMD.
- SEND_*: `tx_valid` is high and `tx_data` is held stable until `tx_ready`; then advance. Reads skip SEND_D.
- WAIT_HDR: discard bytes other than the expected header. Write + 8'h4B goes to RETURN. Read + 8'h44 goes to WAIT_RDATA.
- WAIT_RDATA: the next `rx_valid` byte is captured as read data; go to SPLIT_REQ.
- SPLIT_REQ: hold `split_req` high until `split_grant`; then go to RETURN.
- RETURN: one cycle.
  - `target_ack` = 1.
  - For reads, also `target_data_out_valid` = 1 with `target_data_out` = captured data.
  - Then go to IDLE.
- Any `rx_valid` byte received in IDLE or SEND_* is dropped.

## Timing
- Reset values:
  - `target_ready` = 1.
  - All other outputs = 0, including `timeout_count` and `tx_data`.
  - FSM = IDLE.
- `rst` mid-transaction aborts immediately. No frame completion is attempted; a partially sent frame is the remote's problem.
- `target_ready` is registered. It drops the cycle after address capture and rises the cycle after RETURN.
- `target_split_ack`: a one-cycle pulse, one cycle after a read address is captured.
- `target_data_out` is held until the next read return.
- First `tx_valid` appears 1 cycle after capture (write: after data capture).
- With `tx_ready` constantly high, frame bytes go out on consecutive cycles.
- Minimum write latency, address capture to `target_ack`: 4 TX cycles + response + 1.
- `split_grant` arriving in the same cycle `split_req` first rises is honoured.
- A `split_grant` while not in SPLIT_REQ is ignored.
- `timeout_count` saturates at 8'hFF.

## Configuration
- Macro `BUS_BRIDGE_TARGET_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_HDR and WAIT_RDATA and is cleared on entry to WAIT_HDR.
  - When it reaches `TIMEOUT_CYCLES - 1`, `timeout_count` increments.
  - Write: goes to RETURN (acked).
  - Read: data becomes `ERR_DATA`, go to SPLIT_REQ.
- Undefined:
  - No counter is built; the block waits indefinitely.
  - `timeout_count` is tied to 0.

## Structure
- Package `bus_bridge_pkg` holds:
  - frame byte constants `BRIDGE_CMD_WRITE`, `BRIDGE_CMD_READ`, `BRIDGE_RSP_ACK`, `BRIDGE_RSP_DATA`;
  - the state enum `bridge_tgt_state_t`.
- Shared with the existing bridge initiator wrapper.
- Sub-module `bridge_rsp_timer`: a loadable down-counter with an expiry pulse, instantiated only under the macro.

## Test plan
- Write to 16'h0123 with data 8'h5A, `tx_ready` = 1:
  - TX bytes 57, 01, 23, 5A.
  - Inject 4B → one `target_ack` pulse; `target_ready` returns to 1.
- Read 16'h0456 with `REMOTE_BASE` = 16'h4000:
  - `target_split_ack` pulse; TX bytes 52, 44, 56.
  - Inject 44, C3 → `split_req` high.
  - Grant 3 cycles later → `target_data_out` = C3 with valid + ack in the same cycle.
- Write with data strobe 5 cycles after the address → no TX until the data strobe.
- `tx_ready` toggling 1/0 each cycle → each byte held stable and sent exactly once, in order.
- Stray bytes: inject 99 in IDLE and 10 while in WAIT_HDR of a read, then 44, 7E → 99 and 10 ignored; read returns 7E.
- With the macro and `TIMEOUT_CYCLES` = 50, a read with no response → after 50 cycles `split_req` rises, data = FF, `timeout_count` = 1.
- Assert `rst` mid-frame → IDLE state and reset values on all outputs the next cycle.
